// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarm_pkg
// Description : Shared types and constants for the anti-theft alarm sequencer.
//               Holds the 3-bit state encoding, the seconds-counter width and
//               the default delay values (in seconds).
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

  // Top-level sequencer states; 5..7 are illegal and recover to S_DISARMED
  typedef enum logic [2:0] {
    S_DISARMED  = 3'd0,
    S_ARMING    = 3'd1,
    S_ARMED     = 3'd2,
    S_TRIGGERED = 3'd3,
    S_ALARM_ON  = 3'd4
  } state_t;

  // Width of the saturating seconds counter and of every delay value
  localparam int c_SEC_W = 4;

  // Default delays, in seconds
  localparam int c_DEF_CLK_DIV        = 4;
  localparam int c_DEF_ARM_DELAY      = 6;
  localparam int c_DEF_DRIVER_DELAY   = 8;
  localparam int c_DEF_PASSENGER_DELAY = 15;
  localparam int c_DEF_ALARM_ON       = 10;

endpackage : alarm_pkg
`default_nettype wire

// File: rtl/alarm_timer.sv
`default_nettype none
// ============================================================================
// Module      : alarm_timer
// Description : Seconds timer. A clock prescaler produces a one-second tick;
//               a 4-bit saturating seconds counter counts ticks since the last
//               load, and 'expired' flags when it equals the latched delay.
// Ports       : clock   - system clock, rising edge
//               reset   - synchronous, active-low
//               load    - clears prescaler and seconds, latches 'value'
//               value   - delay in seconds to compare against
//               tick    - high on the cycle whose edge wraps the prescaler
//               expired - seconds == latched delay (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_timer
  import alarm_pkg::*;
#(
  parameter int CLK_DIV = c_DEF_CLK_DIV
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [c_SEC_W-1:0] value,
  output logic               tick,
  output logic               expired
);

  localparam int c_PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_PW-1:0]    c_PRESC_MAX = c_PW'(CLK_DIV - 1);
  localparam logic [c_SEC_W-1:0] c_SEC_MAX   = '1;

  logic [c_PW-1:0]    r_presc;
  logic [c_SEC_W-1:0] r_sec;
  logic [c_SEC_W-1:0] r_limit;

  assign tick    = (r_presc == c_PRESC_MAX);
  assign expired = (r_sec == r_limit);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_presc <= '0;
      r_sec   <= '0;
      r_limit <= '0;
    end else if (load) begin
      r_presc <= '0;
      r_sec   <= '0;
      r_limit <= value;
    end else if (tick) begin
      r_presc <= '0;
      // Saturate so a long-idle timer never wraps back into 'expired'
      if (r_sec != c_SEC_MAX) begin
        r_sec <= r_sec + 1'b1;
      end
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

endmodule : alarm_timer
`default_nettype wire

// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : alarm_controller
// Description : Top-level anti-theft sequencer. Runs the arm countdown, watches
//               the doors once armed, applies the driver/passenger entry delay
//               and drives the siren and dashboard LED.
// Ports       : clock       - system clock, rising edge
//               reset       - synchronous, active-low
//               ignition    - 1 = key on (disarms from any active state)
//               d_door      - 1 = driver door open
//               p_door      - 1 = passenger door open
//               start_count - from arming FSM, countdown may run
//               arm_en      - enable to arming FSM (0 forces it idle)
//               siren       - 1 = siren active
//               status_led  - dashboard LED (registered)
//               state       - current state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int CLK_DIV           = c_DEF_CLK_DIV,
  parameter int T_ARM_DELAY       = c_DEF_ARM_DELAY,
  parameter int T_DRIVER_DELAY    = c_DEF_DRIVER_DELAY,
  parameter int T_PASSENGER_DELAY = c_DEF_PASSENGER_DELAY,
  parameter int T_ALARM_ON        = c_DEF_ALARM_ON
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       d_door,
  input  logic       p_door,
  input  logic       start_count,
  output logic       arm_en,
  output logic       siren,
  output logic       status_led,
  output logic [2:0] state
);

  localparam logic [c_SEC_W-1:0] c_ARM = c_SEC_W'(T_ARM_DELAY);
  localparam logic [c_SEC_W-1:0] c_DRV = c_SEC_W'(T_DRIVER_DELAY);
  localparam logic [c_SEC_W-1:0] c_PAS = c_SEC_W'(T_PASSENGER_DELAY);
  localparam logic [c_SEC_W-1:0] c_ALM = c_SEC_W'(T_ALARM_ON);

  state_t             r_state;
  logic               r_led;
  logic               w_load;
  logic [c_SEC_W-1:0] w_value;
  logic               w_tick;
  logic               w_expired;
  logic               w_door;

  assign w_door = d_door | p_door;

  // Timer load must take effect on the same edge as the state change that
  // requests it, so the load strobe is decoded combinationally.
  always_comb begin
    w_load  = 1'b0;
    w_value = '0;
    case (r_state)
      S_DISARMED: begin
        if (start_count) begin
          w_load  = 1'b1;
          w_value = c_ARM;
        end
      end
      S_ARMED: begin
        if (!ignition && w_door) begin
          w_load  = 1'b1;
          // Driver delay wins when both doors open together
          w_value = d_door ? c_DRV : c_PAS;
        end
      end
      S_TRIGGERED: begin
        if (!ignition && w_expired) begin
          w_load  = 1'b1;
          w_value = c_ALM;
        end
      end
      S_ALARM_ON: begin
        if (!ignition && w_expired && w_door) begin
          w_load  = 1'b1;
          w_value = c_ALM;
        end
      end
      default: begin
        w_load  = 1'b0;
        w_value = '0;
      end
    endcase
  end

  alarm_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (w_load),
    .value   (w_value),
    .tick    (w_tick),
    .expired (w_expired)
  );

  // LED is computed alongside the next state so it is already correct on
  // the cycle the new state becomes visible.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_DISARMED;
      r_led   <= 1'b0;
    end else begin
      case (r_state)
        S_DISARMED: begin
          if (start_count) begin
            r_state <= S_ARMING;
            r_led   <= 1'b1;
          end else begin
            r_led   <= 1'b0;
          end
        end
        S_ARMING: begin
          if (ignition || !start_count) begin
            r_state <= S_DISARMED;
            r_led   <= 1'b0;
          end else if (w_expired) begin
            r_state <= S_ARMED;
            r_led   <= 1'b1;
          end else begin
            r_led   <= 1'b1;
          end
        end
        S_ARMED: begin
          if (ignition) begin
            r_state <= S_DISARMED;
            r_led   <= 1'b0;
          end else if (w_door) begin
            r_state <= S_TRIGGERED;
            r_led   <= 1'b1;
          end else if (w_tick) begin
            r_led   <= ~r_led;
          end
        end
        S_TRIGGERED: begin
          if (ignition) begin
            r_state <= S_DISARMED;
            r_led   <= 1'b0;
          end else begin
            if (w_expired) begin
              r_state <= S_ALARM_ON;
            end
            r_led <= 1'b1;
          end
        end
        S_ALARM_ON: begin
          if (ignition) begin
            r_state <= S_DISARMED;
            r_led   <= 1'b0;
          end else begin
            // With a door still open the timer is reloaded and we stay
            if (w_expired && !w_door) begin
              r_state <= S_ARMED;
            end
            r_led <= 1'b1;
          end
        end
        default: begin
          r_state <= S_DISARMED;
          r_led   <= 1'b0;
        end
      endcase
    end
  end

  assign state      = r_state;
  assign status_led = r_led;
  assign siren      = (r_state == S_ALARM_ON);
  // Illegal encodings decode to the reset value of arm_en
  assign arm_en     = !((r_state == S_ARMED) || (r_state == S_TRIGGERED) ||
                        (r_state == S_ALARM_ON));

endmodule : alarm_controller
`default_nettype wire

// File: tb/tb_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_controller
// Description : Self-checking bench for alarm_controller. A behavioural model
//               tracks state, edges since the last timer load and the LED;
//               directed scenarios are followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_controller;

  localparam int CLK_DIV = 4;
  localparam int T_ARM   = 3;
  localparam int T_DRV   = 2;
  localparam int T_PAS   = 4;
  localparam int T_ALM   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ignition = 1'b0;
  logic       d_door = 1'b0;
  logic       p_door = 1'b0;
  logic       start_count = 1'b0;
  logic       arm_en;
  logic       siren;
  logic       status_led;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: state number, edges since last load, latched delay, LED
  int m_st  = 0;
  int m_e   = 0;
  int m_t   = 0;
  int m_led = 0;

  alarm_controller #(
    .CLK_DIV           (CLK_DIV),
    .T_ARM_DELAY       (T_ARM),
    .T_DRIVER_DELAY    (T_DRV),
    .T_PASSENGER_DELAY (T_PAS),
    .T_ALARM_ON        (T_ALM)
  ) dut (
    .clock       (clk),
    .reset       (rst_n),
    .ignition    (ignition),
    .d_door      (d_door),
    .p_door      (p_door),
    .start_count (start_count),
    .arm_en      (arm_en),
    .siren       (siren),
    .status_led  (status_led),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the currently applied inputs
  task automatic model_edge();
    int sec;
    int ns;
    bit expd;
    bit tck;
    bit ld;
    int nt;
    if (!rst_n) begin
      m_st = 0; m_e = 0; m_t = 0; m_led = 0;
      return;
    end
    sec  = (m_e / CLK_DIV > 15) ? 15 : m_e / CLK_DIV;
    expd = (sec == m_t);
    tck  = ((m_e % CLK_DIV) == CLK_DIV - 1);
    ns = m_st; ld = 0; nt = 0;
    case (m_st)
      0: if (start_count) begin ns = 1; ld = 1; nt = T_ARM; end
      1: if (ignition || !start_count) ns = 0; else if (expd) ns = 2;
      2: if (ignition) ns = 0;
         else if (d_door) begin ns = 3; ld = 1; nt = T_DRV; end
         else if (p_door) begin ns = 3; ld = 1; nt = T_PAS; end
      3: if (ignition) ns = 0; else if (expd) begin ns = 4; ld = 1; nt = T_ALM; end
      4: if (ignition) ns = 0;
         else if (expd) begin
           if (d_door || p_door) begin ld = 1; nt = T_ALM; end
           else ns = 2;
         end
      default: ns = 0;
    endcase
    if (ns == 0) m_led = 0;
    else if (ns != 2) m_led = 1;
    else if (m_st != 2) m_led = 1;
    else m_led = m_led ^ int'(tck);
    m_st = ns;
    if (ld) begin m_e = 0; m_t = nt; end
    else m_e = m_e + 1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("state", int'(state), m_st);
    chk("siren", int'(siren), (m_st == 4) ? 1 : 0);
    chk("arm_en", int'(arm_en), (m_st <= 1) ? 1 : 0);
    chk("status_led", int'(status_led), m_led);
  endtask

  // Step until the DUT reaches tgt or the budget runs out; n = edges taken
  task automatic wait_state(input int tgt, input int lim, output int n);
    n = 0;
    while (int'(state) != tgt && n < lim) begin
      step();
      n++;
    end
    chk("wait_timeout", int'(state), tgt);
  endtask

  initial begin
    int n;
    // Reset
    step();
    chk("rst_state", int'(state), 0);
    chk("rst_arm_en", int'(arm_en), 1);
    chk("rst_led", int'(status_led), 0);
    rst_n = 1'b1;
    step();

    // Arm: 13 edges from ARMING entry to ARMED
    start_count = 1'b1;
    step();
    chk("arm_enter", int'(state), 1);
    wait_state(2, 40, n);
    chk("arm_edges", n, 13);
    chk("armed_arm_en", int'(arm_en), 0);

    // Abort arm
    ignition = 1'b1; step(); ignition = 1'b0;
    chk("ign_disarm", int'(state), 0);
    step();
    chk("rearm", int'(state), 1);
    for (int i = 0; i < 5; i++) step();
    start_count = 1'b0;
    step();
    chk("abort_state", int'(state), 0);
    chk("abort_arm_en", int'(arm_en), 1);
    chk("abort_siren", int'(siren), 0);

    // Re-arm, then both doors together: driver delay
    start_count = 1'b1;
    wait_state(2, 40, n);
    start_count = 1'b0;
    d_door = 1'b1; p_door = 1'b1;
    step();
    d_door = 1'b0; p_door = 1'b0;
    chk("drv_trig", int'(state), 3);
    wait_state(4, 40, n);
    chk("drv_edges", n, 9);
    chk("drv_siren", int'(siren), 1);
    wait_state(2, 40, n);
    chk("alarm_rearm_edges", n, 13);

    // Passenger door, held open through a reload
    p_door = 1'b1;
    step();
    chk("pas_trig", int'(state), 3);
    wait_state(4, 40, n);
    chk("pas_edges", n, 17);
    for (int i = 0; i < 13; i++) step();
    chk("reload_state", int'(state), 4);
    chk("reload_siren", int'(siren), 1);
    p_door = 1'b0;
    wait_state(2, 40, n);
    chk("pas_close_edges", n, 13);

    // Ignition priority in ALARM_ON
    d_door = 1'b1; step(); d_door = 1'b0;
    wait_state(4, 40, n);
    ignition = 1'b1; step(); ignition = 1'b0;
    chk("ign_state", int'(state), 0);
    chk("ign_siren", int'(siren), 0);

    // Reset in ALARM_ON; asserted between edges it has no effect yet
    start_count = 1'b1;
    wait_state(2, 40, n);
    start_count = 1'b0;
    d_door = 1'b1; step(); d_door = 1'b0;
    wait_state(4, 40, n);
    rst_n = 1'b0;
    #2;
    chk("rst_between_edges", int'(state), 4);
    step();
    chk("rst_alarm_state", int'(state), 0);
    chk("rst_alarm_siren", int'(siren), 0);
    chk("rst_alarm_led", int'(status_led), 0);
    chk("rst_alarm_arm_en", int'(arm_en), 1);
    rst_n = 1'b1;

    // Randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      ignition    = ($urandom_range(0, 40) == 0);
      d_door      = ($urandom_range(0, 15) == 0);
      p_door      = ($urandom_range(0, 12) == 0);
      if ($urandom_range(0, 9) == 0) start_count = ~start_count;
      rst_n       = ($urandom_range(0, 150) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_alarm_controller
`default_nettype wire
